// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in byte (16/8) and word (32/16) forms.
// One quotient bit per cycle; signed operands are divided as magnitudes and fixed up afterwards.
module div_unit #(
    parameter int EXTRA_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic        wide,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int WAIT_W = (EXTRA_WAIT > 1) ? $clog2(EXTRA_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXTRA_WAIT);

    state_t             state;
    logic [31:0]        dvd_q;
    logic [15:0]        dvs_q;
    logic               signed_q;
    logic               wide_q;
    logic [15:0]        div_mag_q;
    logic [15:0]        rem_q;
    logic [15:0]        quo_q;
    logic [4:0]         count;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               q_neg;
    logic               r_neg;
    logic               err_q;
    logic [15:0]        fin_q;
    logic [15:0]        fin_r;

    logic               dvd_neg;
    logic               dvs_neg;
    logic [31:0]        dvd_mag;
    logic [15:0]        dvs_mag;
    logic [15:0]        hi_mag;
    logic [15:0]        lo_init;
    logic               prep_err;
    logic [16:0]        rem_shift;
    logic               trial_ok;
    logic [15:0]        trial;
    logic               range_err;
    logic [15:0]        q_fix;
    logic [15:0]        r_fix;

    // Byte mode reuses the word datapath: the high byte sits zero-extended in the
    // partial remainder and the low byte is left-aligned so it shifts out after 8 steps.
    always_comb begin
        dvd_neg = signed_q & (wide_q ? dvd_q[31] : dvd_q[15]);
        dvs_neg = signed_q & (wide_q ? dvs_q[15] : dvs_q[7]);
        if (wide_q) begin
            dvd_mag = dvd_neg ? (32'h0 - dvd_q) : dvd_q;
            dvs_mag = dvs_neg ? (16'h0 - dvs_q) : dvs_q;
            hi_mag  = dvd_mag[31:16];
            lo_init = dvd_mag[15:0];
        end else begin
            dvd_mag = {16'h0, (dvd_neg ? (16'h0 - dvd_q[15:0]) : dvd_q[15:0])};
            dvs_mag = {8'h0, (dvs_neg ? (8'h0 - dvs_q[7:0]) : dvs_q[7:0])};
            hi_mag  = {8'h0, dvd_mag[15:8]};
            lo_init = {dvd_mag[7:0], 8'h0};
        end
        prep_err = (dvs_mag == 16'h0) || (hi_mag >= dvs_mag);

        rem_shift = {rem_q, quo_q[15]};
        trial_ok  = rem_shift >= {1'b0, div_mag_q};
        trial     = 16'(rem_shift - {1'b0, div_mag_q});

        range_err = signed_q & (wide_q ? quo_q[15] : quo_q[7]);
        q_fix     = q_neg ? (16'h0 - quo_q) : quo_q;
        r_fix     = r_neg ? (16'h0 - rem_q) : rem_q;
        if (!wide_q) begin
            q_fix = {8'h0, q_fix[7:0]};
            r_fix = {8'h0, r_fix[7:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_error <= 1'b0;
            quotient  <= 16'h0;
            remainder <= 16'h0;
            dvd_q     <= 32'h0;
            dvs_q     <= 16'h0;
            signed_q  <= 1'b0;
            wide_q    <= 1'b0;
            div_mag_q <= 16'h0;
            rem_q     <= 16'h0;
            quo_q     <= 16'h0;
            count     <= 5'd0;
            wait_cnt  <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            err_q     <= 1'b0;
            fin_q     <= 16'h0;
            fin_r     <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_q    <= dividend;
                        dvs_q    <= divisor;
                        signed_q <= is_signed;
                        wide_q   <= wide;
                        busy     <= 1'b1;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    div_mag_q <= dvs_mag;
                    rem_q     <= hi_mag;
                    quo_q     <= lo_init;
                    q_neg     <= dvd_neg ^ dvs_neg;
                    r_neg     <= dvd_neg;
                    count     <= wide_q ? 5'd16 : 5'd8;
                    if (prep_err) begin
                        done      <= 1'b1;
                        div_error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (trial_ok) begin
                        rem_q <= trial;
                        quo_q <= {quo_q[14:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[15:0];
                        quo_q <= {quo_q[14:0], 1'b0};
                    end
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    fin_q <= q_fix;
                    fin_r <= r_fix;
                    err_q <= range_err;
                    if (EXTRA_WAIT > 0) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end else begin
                        done      <= 1'b1;
                        div_error <= range_err;
                        if (!range_err) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                        end
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        done      <= 1'b1;
                        div_error <= err_q;
                        if (!err_q) begin
                            quotient  <= fin_q;
                            remainder <= fin_r;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start_w;
    logic        is_signed;
    logic        wide;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy, done, div_error;
    logic [15:0] quotient, remainder;
    logic        busy_w, done_w, div_error_w;
    logic [15:0] quotient_w, remainder_w;

    always #5 clk = ~clk;

    div_unit #(.EXTRA_WAIT(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed), .wide(wide),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_error(div_error), .quotient(quotient), .remainder(remainder)
    );

    div_unit #(.EXTRA_WAIT(3)) dut_w (
        .clk(clk), .reset_n(reset_n), .start(start_w), .is_signed(is_signed), .wide(wide),
        .dividend(dividend), .divisor(divisor), .busy(busy_w), .done(done_w),
        .div_error(div_error_w), .quotient(quotient_w), .remainder(remainder_w)
    );

    typedef struct {
        string       name;
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          done_cycle;
    } exp_t;

    exp_t        sb[$];
    int          cycle_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_q = 16'h0;
    logic [15:0] last_r = 16'h0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no done", cycle_cnt);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, ".quotient"},  quotient,  e.q);
                checkOutput({e.name, ".remainder"}, remainder, e.r);
                checkOutput({e.name, ".div_error"}, div_error, e.err);
                checkOutput({e.name, ".done_cycle"}, cycle_cnt, e.done_cycle);
                checkOutput({e.name, ".busy"},      busy,      1);
            end
        end
    end

    task automatic waitIdle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic pushExpect(input string name, input logic [15:0] eq, input logic [15:0] er,
                              input logic eerr, input int done_cycle);
        exp_t e;
        e.name = name;
        e.err  = eerr;
        if (eerr) begin
            e.q = last_q;
            e.r = last_r;
        end else begin
            e.q = eq;
            e.r = er;
            last_q = eq;
            last_r = er;
        end
        e.done_cycle = done_cycle;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic sgn, input logic wd,
                                 input logic [31:0] dvd, input logic [15:0] dvs,
                                 input logic [15:0] eq, input logic [15:0] er,
                                 input logic eerr, input int lat);
        @(negedge clk);
        is_signed = sgn;
        wide      = wd;
        dividend  = dvd;
        divisor   = dvs;
        start     = 1'b1;
        pushExpect(name, eq, er, eerr, cycle_cnt + lat);
        @(negedge clk);
        start = 1'b0;
        waitIdle(name);
    endtask

    initial begin
        int base;
        int lat;

        reset_n   = 1'b0;
        start     = 1'b0;
        start_w   = 1'b0;
        is_signed = 1'b0;
        wide      = 1'b0;
        dividend  = 32'h0;
        divisor   = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst.busy",      busy,      0);
        checkOutput("rst.done",      done,      0);
        checkOutput("rst.div_error", div_error, 0);
        checkOutput("rst.quotient",  quotient,  0);
        checkOutput("rst.remainder", remainder, 0);
        checkOutput("rst.busy_w",    busy_w,    0);
        reset_n = 1'b1;

        //             name        sgn wd dividend       divisor  q        r        err lat
        applyStimulus("uword",     0, 1, 32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 0, 19);
        applyStimulus("sbyte",     1, 0, 32'h0000_FFF9, 16'h0002, 16'h00FD, 16'h00FF, 0, 11);
        applyStimulus("divzero",   1, 1, 32'h0000_1234, 16'h0000, 16'h0000, 16'h0000, 1, 2);
        applyStimulus("uovf",      0, 1, 32'h0002_0000, 16'h0002, 16'h0000, 16'h0000, 1, 2);
        applyStimulus("sovf",      1, 1, 32'h0000_8000, 16'h0001, 16'h0000, 16'h0000, 1, 19);
        applyStimulus("sword_neg", 1, 1, 32'hFFFE_7960, 16'h012C, 16'hFEB3, 16'hFF9C, 0, 19);
        applyStimulus("ubyte",     0, 0, 32'hABCD_03E8, 16'h5507, 16'h008E, 16'h0006, 0, 11);
        applyStimulus("sbyte_min", 1, 0, 32'h0000_FF80, 16'h00FF, 16'h0000, 16'h0000, 1, 11);
        applyStimulus("sbyte_max", 1, 0, 32'h0000_007F, 16'h0001, 16'h007F, 16'h0000, 0, 11);
        applyStimulus("sword_dvs", 1, 1, 32'h0000_0007, 16'hFFFE, 16'hFFFD, 16'h0001, 0, 19);
        applyStimulus("ubyte_ovf", 0, 0, 32'h0000_0200, 16'h0002, 16'h0000, 16'h0000, 1, 2);
        applyStimulus("sword_min", 1, 1, 32'hFFFF_8000, 16'h0001, 16'h0000, 16'h0000, 1, 19);

        // start held high: the second operation is only accepted after the first done
        @(negedge clk);
        is_signed = 1'b0;
        wide      = 1'b1;
        dividend  = 32'h0001_86A0;
        divisor   = 16'h012C;
        start     = 1'b1;
        base      = cycle_cnt;
        pushExpect("held1", 16'h014D, 16'h0064, 0, base + 19);
        pushExpect("held2", 16'h014D, 16'h0064, 0, base + 39);
        while (cycle_cnt < base + 10) @(negedge clk);
        checkOutput("held.busy_mid", busy, 1);
        while (cycle_cnt < base + 20) @(negedge clk);
        checkOutput("held.busy_gap", busy, 0);
        while (cycle_cnt < base + 39) @(negedge clk);
        start = 1'b0;
        waitIdle("held");
        repeat (25) @(negedge clk);

        // reset in the middle of a word divide: outputs clear and no done appears
        @(negedge clk);
        is_signed = 1'b0;
        wide      = 1'b1;
        dividend  = 32'h0001_0000;
        divisor   = 16'h0002;
        start     = 1'b1;
        base      = cycle_cnt;
        @(negedge clk);
        start = 1'b0;
        while (cycle_cnt < base + 8) @(negedge clk);
        checkOutput("midrst.busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst.busy",      busy,      0);
        checkOutput("midrst.done",      done,      0);
        checkOutput("midrst.div_error", div_error, 0);
        checkOutput("midrst.quotient",  quotient,  0);
        checkOutput("midrst.remainder", remainder, 0);
        @(negedge clk);
        reset_n = 1'b1;
        last_q  = 16'h0;
        last_r  = 16'h0;
        repeat (30) @(negedge clk);
        applyStimulus("after_rst", 0, 1, 32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 0, 19);

        // EXTRA_WAIT=3 instance: word divide finishes three cycles later
        @(negedge clk);
        is_signed = 1'b0;
        wide      = 1'b1;
        dividend  = 32'h0001_0000;
        divisor   = 16'h0002;
        start_w   = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        lat     = 1;
        while (done_w !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ew3.done_cycle", lat,         22);
        checkOutput("ew3.quotient",   quotient_w,  16'h8000);
        checkOutput("ew3.remainder",  remainder_w, 16'h0000);
        checkOutput("ew3.div_error",  div_error_w, 0);
        @(negedge clk);
        checkOutput("ew3.busy_after", busy_w, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative restoring divider for the execution unit, covering the DIVU (unsigned) and DIV (signed) instructions in byte and word forms. The combinational ALU handles single-cycle arithmetic and reports its cycle cost. This block takes the opposite approach: it accepts a divide request through a start/done handshake and runs it over many cycles. It returns quotient, remainder and a divide-error indication for the microcode sequencer to act on.

## Interface
- EXTRA_WAIT, default 0: number of idle cycles inserted between FIX and DONE, used to pad latency to match microcode timing.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a divide; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- wide  in  1  1 = 32/16 word divide, 0 = 16/8 byte divide; sampled with start.
- dividend  in  32  dividend; byte mode uses only [15:0].
- divisor  in  16  divisor; byte mode uses only [7:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse marking completion.
- div_error  out  1  valid while done=1; 1 = divide error.
- quotient  out  16  result quotient; byte mode drives [15:8]=0.
- remainder  out  16  result remainder; byte mode drives [15:8]=0.

## Operation
- **States:** IDLE, PREP, ITER, FIX, WAIT, DONE.
- **IDLE:**
  - If start=1, capture dividend, divisor, is_signed and wide into internal registers, then go to PREP.
  - start is ignored in every other state, including DONE.
- **PREP:**
  - In signed mode, convert dividend and divisor to magnitudes and record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Load the iteration counter with 16 (wide) or 8 (byte).
  - Flag an error and go straight to DONE if either:
    - the divisor magnitude is 0, or
    - the magnitude of the dividend high half is ≥ the divisor magnitude (high half = [31:16] for wide, [15:8] for byte); the quotient could not fit.
  - Otherwise go to ITER.
- **ITER:** one restoring step per cycle.
  - Shift {partial remainder, dividend low half} left by 1.
  - Trial-subtract the divisor from the partial remainder. If the subtraction does not borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Width: the partial remainder is 17 bits (word) or 9 bits (byte) so the borrow is not lost.
  - Decrement the counter; when it reaches 0, go to FIX.
- **FIX:**
  - Unsigned: no adjustment.
  - Signed: negate the quotient when the quotient sign is negative, and negate the remainder when the dividend was negative. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed range check: the magnitude quotient must be ≤ 0x7FFF (word) or ≤ 0x7F (byte), otherwise flag an error. The most negative value (0x8000 / 0x80) is therefore always an error.
  - Go to WAIT if EXTRA_WAIT > 0, else to DONE.
- **WAIT:** count EXTRA_WAIT cycles, then go to DONE.
- **DONE:**
  - done=1 and div_error=flag.
  - On no error, update quotient and remainder on entry to DONE. On error, quotient and remainder keep their previous values.
  - Next state is always IDLE.
- **Reset:** asserting reset_n=0 at any time forces IDLE and clears all outputs (busy, done, div_error, quotient, remainder) to 0. An operation interrupted by reset produces no done pulse.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. busy rises in cycle 1.
- Latency to the done pulse:

| Case | done in cycle |
|---|---|
| Word, normal completion | 19 + EXTRA_WAIT |
| Byte, normal completion | 11 + EXTRA_WAIT |
| Error detected in PREP | 2, independent of mode and EXTRA_WAIT |
| Signed range error (detected in FIX) | same as normal completion |

- busy is high through the DONE cycle and low the following cycle. The earliest start for a new operation is that following cycle.
- quotient, remainder and div_error are registered and hold their values until the next DONE.

## Test plan
- **Unsigned word:** dividend 0x0001_0000, divisor 0x0002, is_signed=0, wide=1 → done at cycle 19, quotient 0x8000, remainder 0x0000, div_error=0.
- **Signed byte:** dividend 0xFFF9 (−7), divisor 0x0002, is_signed=1, wide=0 → done at cycle 11, quotient 0x00FD (−3), remainder 0x00FF (−1), div_error=0.
- **Divide by zero:** divisor 0x0000 with any dividend and mode → done at cycle 2, div_error=1, quotient and remainder unchanged from the previous result.
- **Unsigned overflow:** dividend 0x0002_0000, divisor 0x0002, wide=1 → done at cycle 2, div_error=1.
- **Signed overflow:** dividend 0x0000_8000, divisor 0x0001, is_signed=1, wide=1 → no PREP error; done at cycle 19 with div_error=1.
- **Reset and back-to-back:**
  - Pulse reset_n low in cycle 8 of a word divide → all outputs 0, state IDLE, no done pulse.
  - Hold start high continuously → operations are accepted only in the cycle after each done pulse; start during busy has no effect.
  - With EXTRA_WAIT=3, a word divide completes with done at cycle 22.
